// File: rtl/priority_encoder_16x4_q.sv
// priority_encoder_16x4_q: registered 16-to-4 priority encoder with request capture and valid/ready output
module priority_encoder_16x4_q #(
  parameter int N       = 16,
  parameter int CW      = 4,
  parameter int HI_PRIO = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic [N-1:0]               req,
  output logic [CW-1:0]              code,
  output logic                       valid,
  input  logic                       ready,
  output logic [N-1:0]               pending,
  output logic [$clog2(N+1)-1:0]     pend_cnt,
  output logic                       ovf
);
  localparam int PW = $clog2(N+1);
  logic            acc;
  logic [N-1:0]    clr, sel_vec, nxt_pend;
  logic [PW-1:0]   nxt_cnt;
  logic [CW-1:0]   nxt_code;
  // later iterations overwrite earlier ones, so scan order decides the winner
  always_comb begin
    acc      = valid && ready;
    clr      = acc ? N'(1) << code : '0;
    sel_vec  = pending & ~clr;
    nxt_pend = sel_vec | (en ? req : '0);
    nxt_code = '0;
    nxt_cnt  = '0;
    for (int i = 0; i < N; i++) begin
      if (HI_PRIO != 0 ? sel_vec[i] : sel_vec[N-1-i])
        nxt_code = HI_PRIO != 0 ? CW'(i) : CW'(N-1-i);
      nxt_cnt = nxt_cnt + PW'(nxt_pend[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      pend_cnt <= '0;
      code     <= '0;
      valid    <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      pending  <= nxt_pend;
      pend_cnt <= nxt_cnt;
      ovf      <= ovf | (en && |(req & sel_vec));
      if (!valid || acc) begin
        valid <= |sel_vec;
        code  <= nxt_code;
      end
    end
  end
endmodule

// File: tb/tb_priority_encoder_16x4_q.sv
// tb_priority_encoder_16x4_q: scoreboard bench driving a highest-wins and a lowest-wins encoder in parallel
module tb_priority_encoder_16x4_q;
  logic        clk = 0;
  logic        rst_n = 0, en = 0, ready = 0;
  logic [15:0] req = 0;
  logic [3:0]  code_h, code_l;
  logic        valid_h, valid_l, ovf_h, ovf_l;
  logic [15:0] pend_h, pend_l;
  logic [4:0]  cnt_h, cnt_l;
  int checks = 0, errors = 0;
  int q_h[$], q_l[$];
  int mp[2], mv[2], mc[2], mo[2];
  int np[2], nv[2], nc[2], no[2];

  always #5 clk = ~clk;

  priority_encoder_16x4_q #(.HI_PRIO(1)) dut_h (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .code(code_h), .valid(valid_h), .ready(ready), .pending(pend_h), .pend_cnt(cnt_h), .ovf(ovf_h));
  priority_encoder_16x4_q #(.HI_PRIO(0)) dut_l (.clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .code(code_l), .valid(valid_l), .ready(ready), .pending(pend_l), .pend_cnt(cnt_l), .ovf(ovf_l));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d (0x%0h) expected %0d (0x%0h)", name, $time, act, act, exp, exp);
    end
  endtask

  // highest set bit is floor(log2 v); lowest set bit is log2 of v with all higher bits stripped
  function automatic int win(int v, int hi);
    if (v == 0) return 0;
    return hi != 0 ? $clog2(v + 1) - 1 : $clog2(v & -v);
  endfunction

  task automatic cyc();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        np[k] = 0; nv[k] = 0; nc[k] = 0; no[k] = 0;
      end else begin
        int acc, sel;
        acc = mv[k] != 0 && ready;
        sel = acc ? mp[k] & ~(1 << mc[k]) : mp[k];
        if (acc) begin
          if (k == 0) q_h.push_back(mc[k]);
          else q_l.push_back(mc[k]);
        end
        no[k] = mo[k] | int'(en && (int'(req) & sel) != 0);
        np[k] = sel | (en ? int'(req) : 0);
        nv[k] = mv[k]; nc[k] = mc[k];
        if (mv[k] == 0 || acc) begin
          nv[k] = int'(sel != 0);
          nc[k] = win(sel, k == 0 ? 1 : 0);
        end
      end
    end
    @(posedge clk); #1;
    mp = np; mv = nv; mc = nc; mo = no;
    chk("hi_pending", int'(pend_h), mp[0]);
    chk("hi_pend_cnt", int'(cnt_h), $countones(mp[0]));
    chk("hi_valid", int'(valid_h), mv[0]);
    chk("hi_code", int'(code_h), mc[0]);
    chk("hi_ovf", int'(ovf_h), mo[0]);
    chk("lo_pending", int'(pend_l), mp[1]);
    chk("lo_pend_cnt", int'(cnt_l), $countones(mp[1]));
    chk("lo_valid", int'(valid_l), mv[1]);
    chk("lo_code", int'(code_l), mc[1]);
    chk("lo_ovf", int'(ovf_l), mo[1]);
  endtask

  task automatic drive(logic r, logic e, logic [15:0] q, logic rd, int n);
    rst_n = r; en = e; req = q; ready = rd;
    repeat (n) cyc();
  endtask

  // monitor: inputs are stable at the falling edge, so a handshake seen here is the one taken at the next rise
  always @(negedge clk) begin
    if (rst_n && ready && valid_h) begin
      if (q_h.size() == 0) chk("hi_handshake_unexpected", int'(code_h), -1);
      else chk("hi_handshake_code", int'(code_h), q_h.pop_front());
    end
    if (rst_n && ready && valid_l) begin
      if (q_l.size() == 0) chk("lo_handshake_unexpected", int'(code_l), -1);
      else chk("lo_handshake_code", int'(code_l), q_l.pop_front());
    end
  end

  initial begin
    mp = '{0, 0}; mv = '{0, 0}; mc = '{0, 0}; mo = '{0, 0};
    #1;
    drive(0, 1, 16'hFFFF, 1, 2);
    drive(1, 1, 16'h0000, 1, 3);
    drive(1, 1, 16'h0020, 1, 1);
    drive(1, 1, 16'h0000, 1, 3);
    drive(1, 1, 16'h8421, 1, 1);
    drive(1, 1, 16'h0000, 1, 6);
    drive(1, 1, 16'h0008, 0, 1);
    drive(1, 1, 16'h0000, 0, 2);
    drive(1, 1, 16'h8000, 0, 1);
    drive(1, 1, 16'h0000, 0, 2);
    drive(1, 1, 16'h0000, 1, 4);
    drive(1, 1, 16'h0080, 0, 1);
    drive(1, 1, 16'h0000, 0, 1);
    drive(1, 1, 16'h0080, 1, 1);
    drive(1, 1, 16'h0000, 1, 3);
    drive(1, 1, 16'h0004, 0, 1);
    drive(1, 1, 16'h0004, 0, 1);
    drive(1, 0, 16'hFFFF, 1, 3);
    drive(1, 1, 16'hF0F0, 0, 1);
    drive(0, 1, 16'h0F0F, 1, 1);
    drive(1, 1, 16'h0000, 1, 2);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] r;
      r = 16'($urandom) & 16'($urandom) & 16'($urandom);
      drive(($urandom_range(0, 59) != 0), $urandom_range(0, 1) == 1, r, $urandom_range(0, 3) != 0, 1);
    end
    drive(1, 0, 16'h0000, 1, 20);
    chk("hi_queue_left", q_h.size(), 0);
    chk("lo_queue_left", q_l.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
